multi_channel_sequence_counter: RTL and testbench

//  Parametrised bank of CH independent arithmetic-sequence counters sharing one timebase.

---
 rtl/multi_channel_sequence_counter_pkg.sv | 23 ++
 rtl/multi_channel_sequence_counter_sync.sv | 28 ++
 rtl/multi_channel_sequence_counter.sv | 114 +++++++++++
 tb/tb_multi_channel_sequence_counter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/multi_channel_sequence_counter_pkg.sv
// Shared constants and elaboration helpers for the multi-channel sequence counter.
// Holds the default channel vectors, direction encoding and the divider/top-value math.
package multi_channel_sequence_counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [11:0] DEF_START = {4'd1, 4'd0, 4'd0};
  localparam logic [11:0] DEF_STEP  = {4'd2, 4'd2, 4'd1};
  localparam logic [11:0] DEF_LIMIT = {4'd9, 4'd8, 4'd14};

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Largest value reachable from START in whole steps without passing LIMIT.
  function automatic int calc_top(input int start, input int step, input int limit);
    return start + step * ((limit - start) / step);
  endfunction

endpackage

// File: rtl/multi_channel_sequence_counter_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous push-button.
// The output is a single-cycle pulse per rising edge; a held level never re-fires.
module step_pulse_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/multi_channel_sequence_counter.sv
// Bank of CH arithmetic-sequence counters stepped by a shared 1/TICK_HZ divider
// or a synchronised manual push-button; values wrap cyclically between START and TOP.
module multi_channel_sequence_counter
  import multi_channel_sequence_counter_pkg::*;
#(
  parameter int              CLK_HZ  = 1000000,
  parameter int              TICK_HZ = 1,
  parameter int              CH      = 3,
  parameter int              W       = 4,
  parameter logic [CH*W-1:0] START   = DEF_START,
  parameter logic [CH*W-1:0] STEP    = DEF_STEP,
  parameter logic [CH*W-1:0] LIMIT   = DEF_LIMIT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_enable,
  input  logic            i_dir,
  input  logic            i_manual_clock,
  input  logic            i_clear,
  output logic [CH*W-1:0] o_values,
  output logic            o_tick,
  output logic [CH-1:0]   o_wrap
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int W1  = W + 1;

  logic [DW-1:0] r_div;
  logic          r_tick;
  logic          w_auto_step;
  logic          w_man_step;
  logic          w_step;
  dir_e          w_dir;

  step_pulse_sync u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_manual_clock),
    .o_pulse (w_man_step)
  );

  assign w_auto_step = i_enable && (r_div == DW'(DIV - 1));
  assign w_step      = w_auto_step | w_man_step;
  assign w_dir       = dir_e'(i_dir);

  // Any step restarts the timebase, so a manual step pushes the next auto step out by DIV.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                              r_div <= '0;
    else if (i_clear || !i_enable || w_step) r_div <= '0;
    else                                    r_div <= r_div + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_tick <= 1'b0;
    else       r_tick <= w_step & ~i_clear;
  end

  assign o_tick = r_tick;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    localparam int S_I   = int'(START[k*W +: W]);
    localparam int ST_I  = int'(STEP[k*W +: W]);
    localparam int L_I   = int'(LIMIT[k*W +: W]);
    localparam int TOP_I = calc_top(S_I, ST_I, L_I);

    logic [W-1:0] r_val;
    logic         r_wrap;
    logic [W-1:0] w_nxt;
    logic         w_wrap;
    logic [W:0]   w_up;

    // Sums and thresholds are W+1 bits so the carry out of W bits still reads as "past TOP".
    always_comb begin
      w_up   = {1'b0, r_val} + W1'(ST_I);
      w_nxt  = r_val;
      w_wrap = 1'b0;
      if (w_dir == DIR_UP) begin
        if (w_up > W1'(TOP_I)) begin
          w_nxt  = W'(S_I);
          w_wrap = 1'b1;
        end else begin
          w_nxt  = w_up[W-1:0];
        end
      end else begin
        if ({1'b0, r_val} < W1'(S_I + ST_I)) begin
          w_nxt  = W'(TOP_I);
          w_wrap = 1'b1;
        end else begin
          w_nxt  = r_val - W'(ST_I);
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_val  <= W'(S_I);
        r_wrap <= 1'b0;
      end else if (i_clear) begin
        r_val  <= W'(S_I);
        r_wrap <= 1'b0;
      end else if (w_step) begin
        r_val  <= w_nxt;
        r_wrap <= w_wrap;
      end else begin
        r_wrap <= 1'b0;
      end
    end

    assign o_values[k*W +: W] = r_val;
    assign o_wrap[k]          = r_wrap;
  end

endmodule

// File: tb/tb_multi_channel_sequence_counter.sv
// Directed bench for the sequence counter: DIV=10, default START/STEP/LIMIT.
module tb_multi_channel_sequence_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dir;
  logic        man;
  logic        clr;
  logic [11:0] values;
  logic        tick;
  logic [2:0]  wrap;

  int total = 0;
  int bad   = 0;

  multi_channel_sequence_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_dir          (dir),
    .i_manual_clock (man),
    .i_clear        (clr),
    .o_values       (values),
    .o_tick         (tick),
    .o_wrap         (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; dir = 1'b0; man = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_values", {20'd0, values}, 32'h100);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_wrap", {29'd0, wrap}, 0);
    rst = 1'b0;
  endtask

  initial begin
    int ticks, w0, w1, w2, div_bad;

    // Free-running up count over 15 steps
    do_reset();
    enable = 1'b1;
    ticks = 0; w0 = 0; w1 = 0; w2 = 0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      ticks += int'(tick);
      w0 += int'(wrap[0]); w1 += int'(wrap[1]); w2 += int'(wrap[2]);
      if (c == 9)   chk("pre_first_tick", {31'd0, tick}, 0);
      if (c == 10) begin
        chk("step1_values", {20'd0, values}, 32'h321);
        chk("step1_tick", {31'd0, tick}, 1);
      end
      if (c == 50) begin
        chk("step5_values", {20'd0, values}, 32'h105);
        chk("step5_wrap", {29'd0, wrap}, 3'b110);
      end
      if (c == 140) begin
        chk("step14_values", {20'd0, values}, 32'h98E);
        chk("step14_wrap", {29'd0, wrap}, 0);
      end
      if (c == 150) begin
        chk("step15_values", {20'd0, values}, 32'h100);
        chk("step15_wrap", {29'd0, wrap}, 3'b111);
      end
    end
    chk("run_ticks", ticks, 15);
    chk("run_wrap0", w0, 1);
    chk("run_wrap1", w1, 3);
    chk("run_wrap2", w2, 3);

    // One down step from reset wraps every channel to TOP
    do_reset();
    enable = 1'b1; dir = 1'b1;
    repeat (10) @(negedge clk);
    chk("down_values", {20'd0, values}, 32'h98E);
    chk("down_wrap", {29'd0, wrap}, 3'b111);

    // Held manual level gives one step, three edges after the rise
    do_reset();
    man = 1'b1;
    ticks = 0; div_bad = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (dut.r_div != 0) div_bad++;
      if (c == 2) chk("man_edge2_tick", {31'd0, tick}, 0);
      if (c == 3) begin
        chk("man_edge3_tick", {31'd0, tick}, 1);
        chk("man_edge3_values", {20'd0, values}, 32'h321);
      end
      if (c > 3) ticks += int'(tick);
    end
    chk("man_no_repeat", ticks, 0);
    chk("man_div_held", div_bad, 0);
    chk("man_values_held", {20'd0, values}, 32'h321);
    man = 1'b0;

    // Manual pulse coincides with divider terminal count
    do_reset();
    enable = 1'b1;
    ticks = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 7) man = 1'b1;
      if (c == 10) begin
        chk("coinc_values", {20'd0, values}, 32'h321);
        chk("coinc_tick", {31'd0, tick}, 1);
      end
      if (c > 10 && c < 20) ticks += int'(tick);
      if (c == 20) begin
        chk("coinc_gap_ticks", ticks, 0);
        chk("coinc_next_tick", {31'd0, tick}, 1);
        chk("coinc_next_values", {20'd0, values}, 32'h542);
      end
    end
    man = 1'b0;

    // Clear in the same cycle as a step wins
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 19) clr = 1'b1;
      if (c == 20) begin
        chk("clr_values", {20'd0, values}, 32'h100);
        chk("clr_tick", {31'd0, tick}, 0);
        clr = 1'b0;
      end
      if (c == 30) chk("clr_restart_values", {20'd0, values}, 32'h321);
    end

    // Async reset mid-count takes effect before any clock edge
    do_reset();
    enable = 1'b1;
    repeat (15) @(negedge clk);
    chk("pre_areset_values", {20'd0, values}, 32'h321);
    #2 rst = 1'b1;
    #1 chk("areset_values", {20'd0, values}, 32'h100);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
